// File: rtl/lu_pkg.sv
// -----------------------------------------------------------------------------
// lu_pkg
// Shared definitions for the logic unit family: operation-code width and the
// operation enumeration used by lu_core and logic_unit_pipe.
// -----------------------------------------------------------------------------
package lu_pkg;

    localparam int LU_OP_W = 3;

    typedef enum logic [LU_OP_W-1:0] {
        NOT_A = 3'b000,
        AND   = 3'b001,
        NAND  = 3'b010,
        OR    = 3'b011,
        NOR   = 3'b100,
        XOR   = 3'b101,
        XNOR  = 3'b110,
        ZERO  = 3'b111
    } lu_op_e;

endpackage

// File: rtl/lu_core.sv
// -----------------------------------------------------------------------------
// lu_core
// Purely combinational bitwise operation stage. Callers supply the already
// selected operand A and the already conditioned operand B', so this block can
// be replicated per lane in wider variants.
//
// Ports:
//   a_i      in  WIDTH  effective operand A
//   b_i      in  WIDTH  effective operand B' (inversion already applied)
//   op_i     in  3      operation (lu_op_e)
//   result_o out WIDTH  combinational result
// -----------------------------------------------------------------------------
module lu_core
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  lu_op_e           op_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            NOT_A:   result_o = ~a_i;
            AND:     result_o = a_i & b_i;
            NAND:    result_o = ~(a_i & b_i);
            OR:      result_o = a_i | b_i;
            NOR:     result_o = ~(a_i | b_i);
            XOR:     result_o = a_i ^ b_i;
            XNOR:    result_o = ~(a_i ^ b_i);
            ZERO:    result_o = '0;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Registered bitwise logic unit with a one-entry valid/ready output register,
// zero/parity flags and an optional accumulator that can replace operand A.
//
// Build option:
//   LOGIC_UNIT_ACC_EN  defined   -> accumulator register and acc_sel/acc_wr/
//                                   acc_clr behaviour are present
//                      undefined -> no accumulator flops, acc = ACC_RESET,
//                                   A = a, accumulator controls ignored
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous active-high reset
//   in_valid   in   1      request present
//   in_ready   out  1      request can be accepted this cycle
//   a, b       in   WIDTH  operands
//   op         in   3      operation code (lu_op_e)
//   b_inv      in   1      use ~b as B'
//   acc_sel    in   1      take A from the accumulator
//   acc_wr     in   1      write accepted result into the accumulator
//   acc_clr    in   1      synchronous accumulator clear, handshake independent
//   out_valid  out  1      result register holds unconsumed data
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   parity     out  1      XOR reduction of result
//   acc        out  WIDTH  current accumulator value
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import lu_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [LU_OP_W-1:0] op,
    input  logic               b_inv,
    input  logic               acc_sel,
    input  logic               acc_wr,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               parity,
    output logic [WIDTH-1:0]   acc
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] core_res;
    logic             accept;

    // A full register may still accept when it is being drained this cycle.
    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

`ifdef LOGIC_UNIT_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;

    // Operand A reads the pre-update accumulator, so a clear or write in this
    // cycle only affects the next request.
    assign op_a = acc_sel ? acc_q : a;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = ACC_RESET;
        end else if (accept && acc_wr) begin
            acc_d = core_res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= ACC_RESET;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`else
    logic unused_acc_ctrl;

    assign op_a            = a;
    assign acc             = ACC_RESET;
    assign unused_acc_ctrl = &{1'b0, acc_sel, acc_wr, acc_clr};
`endif

    assign op_b = b_inv ? ~b : b;

    lu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a_i      (op_a),
        .b_i      (op_b),
        .op_i     (lu_op_e'(op)),
        .result_o (core_res)
    );

    // Output register: load on accept, otherwise hold data and drop valid
    // once the consumer has taken it.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = core_res;
            zero_d   = ~|core_res;
            parity_d = ^core_res;
        end else if (out_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign parity    = parity_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    localparam int         WIDTH     = 8;
    localparam logic [7:0] ACC_RESET = 8'h00;

`ifdef LOGIC_UNIT_ACC_EN
    localparam bit ACC_EN = 1'b1;
    localparam logic [7:0] CH_EXP0 = 8'h01, CH_EXP1 = 8'h03, CH_EXP2 = 8'h07;
    localparam logic [7:0] CH_ACC  = 8'h07, CH_CLR_RES = 8'h17;
`else
    localparam bit ACC_EN = 1'b0;
    localparam logic [7:0] CH_EXP0 = 8'h81, CH_EXP1 = 8'h82, CH_EXP2 = 8'h84;
    localparam logic [7:0] CH_ACC  = 8'h00, CH_CLR_RES = 8'h90;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic             b_inv, acc_sel, acc_wr, acc_clr;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] result, acc;
    logic             zero, parity;

    logic_unit_pipe #(
        .WIDTH     (WIDTH),
        .ACC_RESET (ACC_RESET)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .b_inv     (b_inv),
        .acc_sel   (acc_sel),
        .acc_wr    (acc_wr),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       b_inv;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[10];

    // Reference model: operation table applied to whole words.
    function automatic logic [7:0] ref_op(input logic [7:0] ea, input logic [7:0] eb,
                                          input logic [2:0] o);
        case (o)
            3'd0: return ~ea;
            3'd1: return ea & eb;
            3'd2: return ~(ea & eb);
            3'd3: return ea | eb;
            3'd4: return ~(ea | eb);
            3'd5: return ea ^ eb;
            3'd6: return ~(ea ^ eb);
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard state for the random phase
    logic       m_valid;
    logic [7:0] m_res;
    logic [7:0] m_acc;

    initial begin
        reset = 1'b1; in_valid = 0; a = 0; b = 0; op = 0; b_inv = 0;
        acc_sel = 0; acc_wr = 0; acc_clr = 0; out_ready = 0;

        vt[0] = '{8'hA5, 8'h0F, 3'd0, 1'b1, 8'h5A};
        vt[1] = '{8'hA5, 8'h0F, 3'd1, 1'b1, 8'hA0};
        vt[2] = '{8'hA5, 8'h0F, 3'd2, 1'b1, 8'h5F};
        vt[3] = '{8'hA5, 8'h0F, 3'd3, 1'b1, 8'hF5};
        vt[4] = '{8'hA5, 8'h0F, 3'd4, 1'b1, 8'h0A};
        vt[5] = '{8'hA5, 8'h0F, 3'd5, 1'b1, 8'h55};
        vt[6] = '{8'hA5, 8'h0F, 3'd6, 1'b1, 8'hAA};
        vt[7] = '{8'hA5, 8'h0F, 3'd7, 1'b1, 8'h00};
        vt[8] = '{8'hF0, 8'h3C, 3'd1, 1'b0, 8'h30};
        vt[9] = '{8'hF0, 8'h3C, 3'd5, 1'b0, 8'hCC};

        // Reset values
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_zero", zero, 1'b1);
        chk("rst_parity", parity, 1'b0);
        chk("rst_acc", acc, ACC_RESET);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Op sweep, back to back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = vt[i].a; b = vt[i].b; op = vt[i].op; b_inv = vt[i].b_inv;
            step();
            chk($sformatf("vec%0d_result", i), result, vt[i].exp);
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_zero", i), zero, vt[i].exp == 8'h00);
            chk($sformatf("vec%0d_parity", i), parity, $countones(vt[i].exp) % 2);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 1'b0);

        // Backpressure: hold result while consumer stalls
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'h33; b = 8'h0F; op = 3'd1; b_inv = 1'b0;
        step();
        chk("bp_first", result, 8'h03);
        op = 3'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
            chk($sformatf("bp_hold%0d", i), result, 8'h03);
            chk($sformatf("bp_valid%0d", i), out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        step();
        chk("bp_new_result", result, 8'h3F);
        chk("bp_new_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        step();
        chk("bp_drained", out_valid, 1'b0);

        // Accumulator chain
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        chk("ch_clr_acc", acc, ACC_RESET);
        in_valid = 1'b1; op = 3'd3; acc_sel = 1'b1; acc_wr = 1'b1; b_inv = 1'b0; a = 8'h80;
        b = 8'h01; step(); chk("ch_res0", result, CH_EXP0);
        b = 8'h02; step(); chk("ch_res1", result, CH_EXP1);
        b = 8'h04; step(); chk("ch_res2", result, CH_EXP2);
        chk("ch_acc", acc, CH_ACC);
        b = 8'h10; acc_clr = 1'b1;
        step();
        chk("ch_clr_res", result, CH_CLR_RES);
        chk("ch_clr_acc2", acc, ACC_RESET);
        in_valid = 1'b0; acc_clr = 1'b0; acc_sel = 1'b0;
        step();

        // Async reset with a pending result
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h5A; b = 8'h00; op = 3'd3; acc_wr = 1'b1;
        step();
        in_valid = 1'b0; acc_wr = 1'b0;
        chk("ar_pending", out_valid, 1'b1);
        chk("ar_acc_loaded", acc, ACC_EN ? 8'h5A : ACC_RESET);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_result", result, 8'h00);
        chk("ar_zero", zero, 1'b1);
        chk("ar_acc", acc, ACC_RESET);
        chk("ar_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        step();

        // Randomized traffic against the transaction-level model
        m_valid = 1'b0; m_res = 8'h00; m_acc = ACC_RESET;
        for (int i = 0; i < 400; i++) begin
            logic       acc_ok;
            logic [7:0] ea, eb, r;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom_range(0, 7));
            b_inv     = 1'($urandom_range(0, 1));
            acc_sel   = 1'($urandom_range(0, 1));
            acc_wr    = 1'($urandom_range(0, 1));
            acc_clr   = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_in_ready", in_ready, !m_valid || out_ready);
            acc_ok = in_valid && (!m_valid || out_ready);
            ea = (ACC_EN && acc_sel) ? m_acc : a;
            eb = b_inv ? ~b : b;
            r  = ref_op(ea, eb, op);
            if (acc_ok) begin
                m_valid = 1'b1;
                m_res   = r;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (ACC_EN) begin
                if (acc_clr) m_acc = ACC_RESET;
                else if (acc_ok && acc_wr) m_acc = r;
            end
            step();
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_result", result, m_res);
            chk("rnd_zero", zero, m_res == 8'h00);
            chk("rnd_parity", parity, $countones(m_res) % 2);
            chk("rnd_acc", acc, m_acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
